vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 105 ++++++++++
 tb/tb_vga_sync_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running pixel/line counters with registered sync, blank and frame pulse.
// Optional macro VGA_SYNC_PIPE_EN delays hs/vs/blank by two cycles to match a ROM + colour register pipeline.
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] r_draw_x;
   logic [9:0] r_draw_y;
   logic       r_hs;
   logic       r_vs;
   logic       r_blank;
   logic       r_frame_start;

   logic [9:0] w_next_x;
   logic [9:0] w_next_y;
   logic       w_line_end;

   always_comb begin
      w_line_end = (r_draw_x == H_LAST);
      w_next_x   = w_line_end ? 10'd0 : r_draw_x + 10'd1;
      w_next_y   = r_draw_y;
      if (w_line_end) begin
         w_next_y = (r_draw_y == V_LAST) ? 10'd0 : r_draw_y + 10'd1;
      end
   end

   // Flags are decoded from the next counter values so they land in the same cycle as DrawX/DrawY.
   // NOTE: non-blocking assignments so every flop in this block samples the pre-edge counter values.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_draw_x      <= 10'd0;
         r_draw_y      <= 10'd0;
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_blank       <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_draw_x      <= w_next_x;
         r_draw_y      <= w_next_y;
         r_hs          <= !((w_next_x >= HS_START) && (w_next_x < HS_END));
         r_vs          <= !((w_next_y >= VS_START) && (w_next_y < VS_END));
         r_blank       <= (w_next_x < H_VIS) && (w_next_y < V_VIS);
         r_frame_start <= (w_next_x == 10'd0) && (w_next_y == 10'd0);
      end
   end

   assign DrawX       = r_draw_x;
   assign DrawY       = r_draw_y;
   assign frame_start = r_frame_start;

`ifdef VGA_SYNC_PIPE_EN
   logic [1:0] r_hs_pipe;
   logic [1:0] r_vs_pipe;
   logic [1:0] r_blank_pipe;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_hs_pipe    <= 2'b11;
         r_vs_pipe    <= 2'b11;
         r_blank_pipe <= 2'b11;
      end else begin
         r_hs_pipe    <= {r_hs_pipe[0], r_hs};
         r_vs_pipe    <= {r_vs_pipe[0], r_vs};
         r_blank_pipe <= {r_blank_pipe[0], r_blank};
      end
   end

   assign hs    = r_hs_pipe[1];
   assign vs    = r_vs_pipe[1];
   assign blank = r_blank_pipe[1];
`else
   assign hs    = r_hs;
   assign vs    = r_vs;
   assign blank = r_blank;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a small-timing instance for full frames and resets,
// plus a default-timing instance checked over its first two lines.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_EN
   localparam int PIPE = 2;
`else
   localparam int PIPE = 0;
`endif

   // Small timing: 32 cycles per line, 22 lines per frame, 704 cycles per frame.
   localparam int S_HV = 16, S_HF = 4, S_HS = 8, S_HB = 4;
   localparam int S_VV = 12, S_VF = 2, S_VS = 3, S_VB = 5;

   logic       vga_clk = 1'b0;
   logic       rst_s, rst_d;
   logic [9:0] sx, sy, dx, dy;
   logic       shs, svs, sbl, sfs;
   logic       dhs, dvs, dbl, dfs;

   int checks = 0;
   int errors = 0;
   int t_s = 0;
   int t_d = 0;

   always #5 vga_clk = ~vga_clk;

   vga_sync_gen #(
      .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
   ) u_small (
      .vga_clk(vga_clk), .reset(rst_s), .DrawX(sx), .DrawY(sy),
      .hs(shs), .vs(svs), .blank(sbl), .frame_start(sfs)
   );

   vga_sync_gen u_dflt (
      .vga_clk(vga_clk), .reset(rst_d), .DrawX(dx), .DrawY(dy),
      .hs(dhs), .vs(dvs), .blank(dbl), .frame_start(dfs)
   );

   typedef struct {
      int   x;
      int   y;
      logic hs;
      logic vs;
      logic blank;
      logic fs;
   } exp_t;

   typedef struct {
      int   t;
      int   x;
      int   y;
      logic hs;
      logic vs;
      logic blank;
      logic fs;
      logic chk_sync;
   } vec_t;

   // Reference: position is simply elapsed cycles since reset folded by line and frame length.
   function automatic exp_t ref_model(input int t, hv, hf, hsn, hb, vv, vf, vsn, vb);
      exp_t e;
      int ht, vt, td, xd, yd;
      ht   = hv + hf + hsn + hb;
      vt   = vv + vf + vsn + vb;
      e.x  = t % ht;
      e.y  = (t / ht) % vt;
      e.fs = (t > 0) && (e.x == 0) && (e.y == 0);
      td   = t - PIPE;
      if (td < 0) begin
         e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b1;
      end else begin
         xd      = td % ht;
         yd      = (td / ht) % vt;
         e.hs    = !((xd >= hv + hf) && (xd < hv + hf + hsn));
         e.vs    = !((yd >= vv + vf) && (yd < vv + vf + vsn));
         e.blank = (xd < hv) && (yd < vv);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t_s=%0d t_d=%0d)", name, act, exp, t_s, t_d);
      end
   endtask

   // One clock: reset level seen at the edge decides whether elapsed time restarts.
   task automatic step();
      logic rs, rd;
      rs = rst_s;
      rd = rst_d;
      @(posedge vga_clk);
      t_s = rs ? 0 : t_s + 1;
      t_d = rd ? 0 : t_d + 1;
      @(negedge vga_clk);
   endtask

   task automatic check_small(input string tag);
      exp_t e;
      e = ref_model(t_s, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
      check({tag, ".x"}, 32'(sx), 32'(e.x));
      check({tag, ".y"}, 32'(sy), 32'(e.y));
      check({tag, ".hs"}, 32'(shs), 32'(e.hs));
      check({tag, ".vs"}, 32'(svs), 32'(e.vs));
      check({tag, ".blank"}, 32'(sbl), 32'(e.blank));
      check({tag, ".fs"}, 32'(sfs), 32'(e.fs));
   endtask

   task automatic check_dflt(input string tag);
      exp_t e;
      e = ref_model(t_d, 640, 16, 96, 48, 480, 10, 2, 33);
      check({tag, ".x"}, 32'(dx), 32'(e.x));
      check({tag, ".y"}, 32'(dy), 32'(e.y));
      check({tag, ".hs"}, 32'(dhs), 32'(e.hs));
      check({tag, ".vs"}, 32'(dvs), 32'(e.vs));
      check({tag, ".blank"}, 32'(dbl), 32'(e.blank));
      check({tag, ".fs"}, 32'(dfs), 32'(e.fs));
   endtask

   task automatic pulse_reset_small();
      rst_s = 1'b1;
      step();
      rst_s = 1'b0;
   endtask

   initial begin
      vec_t vecs[12];
      int   n_blank, n_vs, n_hs, n_fs, rst_left;
      int   hs_fall_x, bl_fall_x;

      // Hand-picked points, chosen away from edges so they hold with or without the sync pipeline.
      vecs[0]  = '{0,   0,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{1,   1,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{10,  10, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{24,  24, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{31,  31, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{35,  3,  1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{453, 5,  14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{543, 31, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{554, 10, 17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{703, 31, 21, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{704, 0,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{708, 4,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_s = 1'b1;
      rst_d = 1'b1;
      step();
      step();
      rst_s = 1'b0;

      foreach (vecs[i]) begin
         while (t_s < vecs[i].t) step();
         check($sformatf("vec%0d.x", i), 32'(sx), 32'(vecs[i].x));
         check($sformatf("vec%0d.y", i), 32'(sy), 32'(vecs[i].y));
         check($sformatf("vec%0d.fs", i), 32'(sfs), 32'(vecs[i].fs));
         if (vecs[i].chk_sync) begin
            check($sformatf("vec%0d.hs", i), 32'(shs), 32'(vecs[i].hs));
            check($sformatf("vec%0d.vs", i), 32'(svs), 32'(vecs[i].vs));
            check($sformatf("vec%0d.blank", i), 32'(sbl), 32'(vecs[i].blank));
         end
      end

      // One full frame after reset: per-cycle model plus aggregate counts.
      pulse_reset_small();
      n_blank = 0; n_vs = 0; n_hs = 0; n_fs = 0;
      for (int c = 0; c <= 705; c++) begin
         check_small("frame");
         if (t_s >= PIPE && t_s <= PIPE + 703) begin
            n_blank += int'(sbl);
            n_vs    += int'(!svs);
            n_hs    += int'(!shs);
         end
         if (t_s >= 1 && t_s <= 704) n_fs += int'(sfs);
         step();
      end
      check("frame.blank_count", 32'(n_blank), 32'(S_HV * S_VV));
      check("frame.vs_low_count", 32'(n_vs), 32'(S_VS * 32));
      check("frame.hs_low_count", 32'(n_hs), 32'(S_HS * 22));
      check("frame.fs_count", 32'(n_fs), 32'd1);

      // Mid-frame resets: once with hs and vs both active, once in the visible area.
      pulse_reset_small();
      while (t_s < 15 * 32 + 24) step();
      check("midsync.pre_x", 32'(sx), 32'd24);
      check("midsync.pre_y", 32'(sy), 32'd15);
      check("midsync.pre_hs", 32'(shs), 32'd0);
      check("midsync.pre_vs", 32'(svs), 32'd0);
      pulse_reset_small();
      check("midsync.x", 32'(sx), 32'd0);
      check("midsync.y", 32'(sy), 32'd0);
      check("midsync.hs", 32'(shs), 32'd1);
      check("midsync.vs", 32'(svs), 32'd1);
      check("midsync.blank", 32'(sbl), 32'd1);
      check("midsync.fs", 32'(sfs), 32'd0);
      step();
      check("midsync.next_x", 32'(sx), 32'd1);
      check("midsync.next_y", 32'(sy), 32'd0);

      while (t_s < 5 * 32 + 10) step();
      check("midvis.pre_x", 32'(sx), 32'd10);
      check("midvis.pre_y", 32'(sy), 32'd5);
      pulse_reset_small();
      check("midvis.x", 32'(sx), 32'd0);
      check("midvis.y", 32'(sy), 32'd0);
      check("midvis.hs", 32'(shs), 32'd1);
      check("midvis.vs", 32'(svs), 32'd1);
      check("midvis.blank", 32'(sbl), 32'd1);
      check("midvis.fs", 32'(sfs), 32'd0);
      step();
      check("midvis.next_x", 32'(sx), 32'd1);

      // Randomly timed reset pulses of 1..3 cycles against the model.
      rst_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (rst_left > 0) begin
            rst_s = 1'b1;
            rst_left--;
         end else begin
            rst_s = 1'b0;
            if ($urandom_range(0, 199) == 0) rst_left = int'($urandom_range(1, 3));
         end
         step();
         check_small("rand");
      end
      rst_s = 1'b0;

      // Default timing: first two lines, hs width and fall positions.
      rst_d = 1'b0;
      n_hs = 0;
      hs_fall_x = -1;
      bl_fall_x = -1;
      for (int c = 0; c < 1700; c++) begin
         step();
         check_dflt("dflt");
         if (t_d >= PIPE && t_d <= PIPE + 799) n_hs += int'(!dhs);
         if (t_d < 800 && !dhs && hs_fall_x < 0) hs_fall_x = int'(dx);
         if (t_d < 800 && !dbl && bl_fall_x < 0) bl_fall_x = int'(dx);
         if (t_d == 800) begin
            check("dflt.line_x", 32'(dx), 32'd0);
            check("dflt.line_y", 32'(dy), 32'd1);
         end
      end
      check("dflt.hs_low_count", 32'(n_hs), 32'd96);
      check("dflt.hs_fall_x", 32'(hs_fall_x), 32'(656 + PIPE));
      check("dflt.blank_fall_x", 32'(bl_fall_x), 32'(640 + PIPE));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
